// File: rtl/if_id_skid_reg_pkg.sv
// Shared definitions for the fetch-to-decode skid register.
//   DataWDefault : default instruction / PC width
//   NopInstr     : word shown to decode while no instruction is valid
//   state_e      : skid buffer occupancy state
package if_id_skid_reg_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam logic [31:0] NopInstr     = 32'h0000_0000;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

endpackage

// File: rtl/if_id_skid_reg_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
//   clk_i   : clock
//   rst_i   : asynchronous active-low reset, clears the count
//   inc_i   : add one this cycle (ignored once saturated)
//   count_o : current count
module if_id_skid_reg_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// Fetch-to-decode pipeline register built as a two-slot skid buffer.
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   valid_i/ready_o        : fetch-side handshake (ready_o is a pure register decode)
//   instr_i, pc_plus4_i    : fetched instruction and its PC+4
//   flush_i                : drop everything held and incoming (branch/jump redirect)
//   valid_o/ready_i        : decode-side handshake
//   instr_o, pc_plus4_o    : main slot contents (instr_o = NOP_INSTR when not valid)
//   imm16_o                : instr_o[15:0] for the sign-extend stage
//   stall_cnt_o            : saturating count of cycles with valid_o & !ready_i
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int unsigned        DATA_W    = DataWDefault,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(NopInstr),
  parameter int unsigned        CNT_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [15:0]       imm16_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_instr_q, main_instr_d;
  logic [DATA_W-1:0] main_pc_q, main_pc_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [DATA_W-1:0] skid_pc_q, skid_pc_d;

  logic accept, xfer;

  assign valid_o = (state_q != StEmpty);
  assign ready_o = (state_q != StSkid);
  assign accept  = valid_i & ready_o;
  assign xfer    = valid_o & ready_i;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_instr_d = instr_i;
          main_pc_d    = pc_plus4_i;
          state_d      = StFull;
        end
      end
      StFull: begin
        if (accept && xfer) begin
          main_instr_d = instr_i;
          main_pc_d    = pc_plus4_i;
        end else if (accept) begin
          skid_instr_d = instr_i;
          skid_pc_d    = pc_plus4_i;
          state_d      = StSkid;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (xfer) begin
          main_instr_d = skid_instr_q;
          main_pc_d    = skid_pc_q;
          state_d      = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush drops the incoming word without loading it, so pc_plus4_o keeps
    // showing the last delivered PC+4 while the buffer is empty.
    if (flush_i) begin
      state_d      = StEmpty;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StEmpty;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign instr_o    = valid_o ? main_instr_q : NOP_INSTR;
  assign imm16_o    = instr_o[15:0];
  assign pc_plus4_o = main_pc_q;

  if_id_skid_reg_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (valid_o & ~ready_i),
    .count_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, ready_i, flush_i;
  logic [31:0] instr_i, pc_plus4_i;

  logic        ready_o, valid_o;
  logic [31:0] instr_o, pc_plus4_o;
  logic [15:0] imm16_o;
  logic [7:0]  stall_cnt_o;

  logic        s_ready_o, s_valid_o;
  logic [31:0] s_instr_o, s_pc_plus4_o;
  logic [15:0] s_imm16_o;
  logic [2:0]  s_stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  if_id_skid_reg dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .instr_i     (instr_i),
    .pc_plus4_i  (pc_plus4_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .instr_o     (instr_o),
    .imm16_o     (imm16_o),
    .pc_plus4_o  (pc_plus4_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  if_id_skid_reg #(
    .CNT_W (3)
  ) dut_s (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (s_ready_o),
    .instr_i     (instr_i),
    .pc_plus4_i  (pc_plus4_i),
    .flush_i     (flush_i),
    .valid_o     (s_valid_o),
    .ready_i     (ready_i),
    .instr_o     (s_instr_o),
    .imm16_o     (s_imm16_o),
    .pc_plus4_o  (s_pc_plus4_o),
    .stall_cnt_o (s_stall_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    valid_i    = v;
    instr_i    = ins;
    pc_plus4_i = pc;
    ready_i    = rdy;
    flush_i    = fl;
  endtask

  logic [31:0] stream_ins [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [31:0] stream_pc  [4] = '{32'h8, 32'hC, 32'h10, 32'h14};

  initial begin
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_ready", ready_o, 1);
    check_eq("rst_instr", instr_o, 0);
    check_eq("rst_pc", pc_plus4_o, 0);
    check_eq("rst_cnt", stall_cnt_o, 0);
    rst_i = 1'b1;
    step();

    // First instruction, one-cycle latency.
    drive(1'b1, 32'h2008_FFFC, 32'h4, 1'b1, 1'b0);
    step();
    check_eq("first_valid", valid_o, 1);
    check_eq("first_instr", instr_o, 32'h2008_FFFC);
    check_eq("first_imm", imm16_o, 16'hFFFC);
    check_eq("first_ready", ready_o, 1);
    check_eq("first_pc", pc_plus4_o, 32'h4);

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream_ins[i], stream_pc[i], 1'b1, 1'b0);
      step();
      check_eq($sformatf("stream_instr%0d", i), instr_o, stream_ins[i]);
      check_eq($sformatf("stream_pc%0d", i), pc_plus4_o, stream_pc[i]);
      check_eq($sformatf("stream_ready%0d", i), ready_o, 1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check_eq("drain_valid", valid_o, 0);
    check_eq("drain_nop", instr_o, 0);
    check_eq("drain_pc_hold", pc_plus4_o, 32'h14);
    check_eq("drain_cnt", stall_cnt_o, 0);

    // Back-pressure: A then B with decode stalled.
    drive(1'b1, 32'hAAAA_0001, 32'h100, 1'b0, 1'b0);
    step();
    check_eq("bp_a_instr", instr_o, 32'hAAAA_0001);
    check_eq("bp_a_cnt", stall_cnt_o, 0);
    drive(1'b1, 32'hBBBB_0002, 32'h104, 1'b0, 1'b0);
    step();
    check_eq("bp_b_ready", ready_o, 0);
    check_eq("bp_b_hold", instr_o, 32'hAAAA_0001);
    check_eq("bp_b_cnt", stall_cnt_o, 1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    check_eq("bp_hold_instr", instr_o, 32'hAAAA_0001);
    check_eq("bp_hold_pc", pc_plus4_o, 32'h100);
    check_eq("bp_hold_cnt", stall_cnt_o, 3);
    check_eq("bp_hold_ready", ready_o, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check_eq("bp_out_b", instr_o, 32'hBBBB_0002);
    check_eq("bp_out_b_pc", pc_plus4_o, 32'h104);
    check_eq("bp_ready_back", ready_o, 1);
    check_eq("bp_cnt_stop", stall_cnt_o, 3);
    step();
    check_eq("bp_empty", valid_o, 0);

    // Flush while in SKID with an incoming instruction C.
    drive(1'b1, 32'hDDDD_0003, 32'h200, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hEEEE_0004, 32'h204, 1'b0, 1'b0);
    step();
    check_eq("fl_skid_ready", ready_o, 0);
    check_eq("fl_pre_cnt", stall_cnt_o, 4);
    drive(1'b1, 32'hCCCC_0005, 32'h208, 1'b0, 1'b1);
    step();
    check_eq("fl_valid", valid_o, 0);
    check_eq("fl_instr", instr_o, 0);
    check_eq("fl_ready", ready_o, 1);
    check_eq("fl_cnt", stall_cnt_o, 5);
    check_eq("fl_pc_hold", pc_plus4_o, 32'h200);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check_eq("fl_no_ghost1", valid_o, 0);
    step();
    check_eq("fl_no_ghost2", valid_o, 0);

    // Saturation: both counters at 5, hold stall for 9 cycles.
    drive(1'b1, 32'hF00D_0006, 32'h300, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    check_eq("sat_s_at7", s_stall_cnt_o, 7);
    for (int i = 0; i < 7; i++) step();
    check_eq("sat_s_hold", s_stall_cnt_o, 7);
    check_eq("sat_wide", stall_cnt_o, 14);
    check_eq("sat_hold_instr", instr_o, 32'hF00D_0006);

    // Async reset mid-cycle while in SKID.
    drive(1'b1, 32'h6060_0007, 32'h304, 1'b0, 1'b0);
    step();
    check_eq("ar_skid_ready", ready_o, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst_i = 1'b0;
    #1;
    check_eq("ar_valid", valid_o, 0);
    check_eq("ar_ready", ready_o, 1);
    check_eq("ar_instr", instr_o, 0);
    check_eq("ar_pc", pc_plus4_o, 0);
    check_eq("ar_cnt", stall_cnt_o, 0);
    #1 rst_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check_eq("ar_post_valid", valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Fetch-to-decode pipeline register for the CO datapath; sits directly upstream of the decode stage.
- Delivers the instruction word whose low half feeds the 16-to-32 sign-extend stage.
- Two-slot skid buffer with valid/ready on both sides, a flush for branch/jump redirects, and a saturating stall counter.
- Replaces the plain instruction wire so decode can back-pressure fetch without losing an instruction.

Parameters:
- DATA_W, 32, instruction and PC width.
- NOP_INSTR, 32'h0000_0000, word driven on instr_o whenever valid_o=0.
- CNT_W, 8, width of the saturating stall counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous active-low reset.
- valid_i  input  1  fetch presents an instruction.
- ready_o  output  1  buffer can accept; registered.
- instr_i  input  DATA_W  fetched instruction.
- pc_plus4_i  input  DATA_W  PC+4 of the fetched instruction.
- flush_i  input  1  discard all buffered and incoming instructions.
- valid_o  output  1  decode-side instruction valid.
- ready_i  input  1  decode accepts this cycle.
- instr_o  output  DATA_W  instruction to decode.
- imm16_o  output  16  instr_o[15:0], to the sign-extend stage.
- pc_plus4_o  output  DATA_W  PC+4 paired with instr_o.
- stall_cnt_o  output  CNT_W  cycles with valid_o=1 and ready_i=0, saturating.

Behaviour:
- Clock, reset and transfer rules:
  - Clock is clk_i; reset is rst_i, asynchronous and active-low.
  - Accept = valid_i & ready_o; transfer out = valid_o & ready_i.
- Reset values while rst_i=0: state EMPTY, valid_o=0, ready_o=1, instr_o=NOP_INSTR, imm16_o=NOP_INSTR[15:0], pc_plus4_o=0, stall_cnt_o=0, skid slot cleared. Reset mid-operation drops all held instructions.
- Storage: main slot drives the outputs; skid slot holds one extra entry. ready_o=1 exactly when the skid slot is empty, registered and never combinational from ready_i.
- States and transitions:
  - EMPTY: accept -> main<=input, go FULL. Otherwise stay.
  - FULL, accept & transfer -> main<=input, stay FULL.
  - FULL, accept & !transfer -> skid<=input, go SKID, ready_o=0 next cycle.
  - FULL, !accept & transfer -> go EMPTY.
  - FULL, neither -> hold.
  - SKID (ready_o=0, no accept possible): transfer -> main<=skid, go FULL, ready_o=1 next cycle. Otherwise hold.
- Latency: instruction accepted in EMPTY appears on valid_o the next cycle. Throughput is 1/cycle while ready_i=1.
- Outputs hold stable while valid_o=1 and ready_i=0. When valid_o=0, instr_o=NOP_INSTR and pc_plus4_o holds its last value.
- Flush: flush_i=1 at an edge -> next state EMPTY, valid_o=0, ready_o=1, both slots invalid.
  - flush_i overrides a simultaneous accept; the incoming instruction is dropped.
  - A simultaneous transfer is still counted as consumed by decode.
- Stall counter:
  - Increments by 1 each cycle valid_o=1 & ready_i=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush; cleared only by reset.
- Ordering: FIFO; no instruction is duplicated or reordered.

Decomposition:
- Shared package: NOP_INSTR constant, state encoding (EMPTY=2'd0, FULL=2'd1, SKID=2'd2), DATA_W default.
- Optional sub-module sat_counter (CNT_W, inc, count) for stall_cnt_o. The skid logic stays in one module.

Test Plan:
- Reset, then valid_i=1 with instr_i=32'h2008_FFFC, pc_plus4_i=4, ready_i=1 -> next cycle valid_o=1, instr_o=32'h2008_FFFC, imm16_o=16'hFFFC, ready_o=1.
- Streaming: 4 instructions on consecutive cycles with ready_i=1 -> same 4 words out in order, one cycle late, ready_o stays 1.
- Back-pressure: ready_i=0 from FULL, push A then B -> ready_o=0 after B, instr_o=A held, stall_cnt_o increments each cycle. ready_i=1 -> A then B out, ready_o=1 again.
- Flush in SKID state with simultaneous valid_i=1 (C) -> next cycle valid_o=0, instr_o=0, ready_o=1; C never appears.
- Saturation: CNT_W=3, hold valid_o=1 and ready_i=0 for 10 cycles -> stall_cnt_o=7.
- Async reset asserted mid-cycle in SKID -> outputs take reset values immediately, before the next clock edge.
